csr_mtrap_unit: RTL and testbench

// - Machine-mode CSR file with trap sequencing for the single-issue NPC core.
// - Sits beside EXU: serves CSRRW/S/C, latches trap state on exception/interrupt, restores on mret.
// - Generalises the old fixed 64-bit file: XLEN-parametric, full mstatus MIE/MPIE stacking,

---
 rtl/csr_mtrap_unit_pkg.sv | 50 +++++
 rtl/csr_mtrap_unit_if.sv | 23 ++
 rtl/csr_trap_ctrl.sv | 98 +++++++++
 rtl/csr_mtrap_unit.sv | 173 +++++++++++++++++
 tb/tb_csr_mtrap_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_mtrap_unit_pkg.sv
// Shared constants for the machine-mode CSR / trap unit: CSR addresses,
// access-op encodings, status/enable/pending bit positions and interrupt codes.
package csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // CSR instruction flavours
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie / mip bit positions
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  // Interrupt exception codes (low bits of mcause)
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

  // Winning event of a cycle after priority resolution
  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_EXC,
    EVT_IRQ,
    EVT_MRET
  } trap_evt_e;

endpackage

// File: rtl/csr_mtrap_unit_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface csr_mtrap_unit_if #(
  parameter int XLEN = 64
);
  import csr_pkg::*;

  logic [11:0]     csr_addr;
  csr_op_e         csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_addr, csr_op, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata,
    output csr_rdata, csr_illegal
  );

endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap sequencer: resolves exception / interrupt / mret priority, decides
// whether an interrupt is taken, builds the trap cause/epc/tval and the
// fetch target, and registers the one-cycle redirect pulse.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            status_mie,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            irq_take,
  output logic            trap_en,
  output logic            mret_en,
  output logic            csr_wr_allow,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_evt_e       evt;
  logic            irq_ext_hit;
  logic            irq_tmr_hit;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] next_target;

  // Interrupt qualification and per-cycle event priority (exc > irq > mret > CSR write)
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    evt         = EVT_NONE;
    irq_ext_hit = irq_ext & mie_meie;
    irq_tmr_hit = irq_timer & mie_mtie;
    irq_take    = status_mie & ~exc_valid & (irq_ext_hit | irq_tmr_hit);
    irq_code    = irq_ext_hit ? IRQ_CODE_EXT : IRQ_CODE_TIMER;
    if (exc_valid)     evt = EVT_EXC;
    else if (irq_take) evt = EVT_IRQ;
    else if (mret)     evt = EVT_MRET;
  end

  // Trap payload and fetch target for the winning event
  always_comb begin
    mtvec_base  = mtvec & ~XLEN'(3);
    trap_cause  = '0;
    trap_epc    = '0;
    trap_tval   = '0;
    next_target = '0;
    case (evt)
      EVT_EXC: begin
        trap_cause  = exc_cause;
        trap_epc    = exc_pc & ~XLEN'(3);
        trap_tval   = exc_tval;
        next_target = mtvec_base;
      end
      EVT_IRQ: begin
        trap_cause  = {1'b1, {(XLEN-5){1'b0}}, irq_code};
        trap_epc    = irq_pc & ~XLEN'(3);
        // Vectored mode only for mode==01; mode 1x falls back to direct.
        next_target = (mtvec[1:0] == 2'b01)
                    ? mtvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                    : mtvec_base;
      end
      EVT_MRET: next_target = mepc;
      default:  next_target = '0;
    endcase
  end

  assign trap_en      = (evt == EVT_EXC) || (evt == EVT_IRQ);
  assign mret_en      = (evt == EVT_MRET);
  assign csr_wr_allow = (evt == EVT_NONE);

  // Registered redirect: pulses the cycle after each trap/mret edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      redirect_valid <= trap_en | mret_en;
      if (trap_en | mret_en) redirect_pc <= next_target;
    end
  end

endmodule

// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file for the single-issue core: CSR read/modify/write,
// mstatus MIE/MPIE stacking, trap state capture, mret restore, counters.
// Priority and redirect generation live in csr_trap_ctrl.
module csr_mtrap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] MTVEC_RST    = 'h8000_0000,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_mtrap_unit_if.slave csr,
  input  logic            instr_retire,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] irq_pc,
  output logic            irq_take,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  // Architectural state
  logic            st_mie, st_mpie;
  logic            ie_mtie, ie_meie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] mcycle, minstret;

  // Access decode
  logic            addr_known, access, wr_intent, illegal, csr_we;
  logic [XLEN-1:0] rdata_raw, wval;

  // Trap controller handshake
  logic            trap_en, mret_en, csr_wr_allow;
  logic [XLEN-1:0] trap_cause, trap_epc, trap_tval;

  csr_trap_ctrl #(.XLEN(XLEN)) u_trap_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .irq_timer      (irq_timer),
    .irq_ext        (irq_ext),
    .irq_pc         (irq_pc),
    .status_mie     (st_mie),
    .mie_mtie       (ie_mtie),
    .mie_meie       (ie_meie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .irq_take       (irq_take),
    .trap_en        (trap_en),
    .mret_en        (mret_en),
    .csr_wr_allow   (csr_wr_allow),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .trap_tval      (trap_tval),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Read mux: architectural view of the addressed CSR
  always_comb begin
    addr_known = 1'b1;
    rdata_raw  = '0;
    case (csr.csr_addr)
      CSR_MSTATUS: begin
        rdata_raw[MSTATUS_MIE]                   = st_mie;
        rdata_raw[MSTATUS_MPIE]                  = st_mpie;
        rdata_raw[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE: begin
        rdata_raw[MIE_MTIE] = ie_mtie;
        rdata_raw[MIE_MEIE] = ie_meie;
      end
      CSR_MIP: begin
        rdata_raw[MIP_MTIP] = irq_timer;
        rdata_raw[MIP_MEIP] = irq_ext;
      end
      CSR_MTVEC:    rdata_raw = mtvec;
      CSR_MSCRATCH: rdata_raw = mscratch;
      CSR_MEPC:     rdata_raw = mepc;
      CSR_MCAUSE:   rdata_raw = mcause;
      CSR_MTVAL:    rdata_raw = mtval;
      CSR_MCYCLE:   rdata_raw = mcycle;
      CSR_MINSTRET: rdata_raw = minstret;
      CSR_MHARTID:  rdata_raw = '0;
      default:      addr_known = 1'b0;
    endcase
  end

  // Legality and write-value computation; RS/RC with a zero operand is a pure read
  always_comb begin
    access    = (csr.csr_op != CSR_OP_NONE);
    wr_intent = (csr.csr_op == CSR_OP_RW) || (access && (csr.csr_wdata != '0));
    illegal   = access && (!addr_known || (wr_intent && (csr.csr_addr[11:10] == 2'b11)));
    csr_we    = access && !illegal && wr_intent && csr_wr_allow;
    case (csr.csr_op)
      CSR_OP_RW: wval = csr.csr_wdata;
      CSR_OP_RS: wval = rdata_raw | csr.csr_wdata;
      CSR_OP_RC: wval = rdata_raw & ~csr.csr_wdata;
      default:   wval = rdata_raw;
    endcase
  end

  assign csr.csr_rdata   = (access && !illegal) ? rdata_raw : '0;
  assign csr.csr_illegal = illegal;

  // Trap capture, mret restore and software CSR writes, in priority order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      ie_mtie  <= 1'b0;
      ie_meie  <= 1'b0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_en) begin
      mepc    <= trap_epc;
      mcause  <= trap_cause;
      mtval   <= trap_tval;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_en) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr.csr_addr)
        CSR_MSTATUS: begin
          st_mie  <= wval[MSTATUS_MIE];
          st_mpie <= wval[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          ie_mtie <= wval[MIE_MTIE];
          ie_meie <= wval[MIE_MEIE];
        end
        CSR_MTVEC:    mtvec    <= wval;
        CSR_MSCRATCH: mscratch <= wval;
        CSR_MEPC:     mepc     <= wval & ~XLEN'(3);
        CSR_MCAUSE:   mcause   <= wval;
        CSR_MTVAL:    mtval    <= wval;
        default:      ;
      endcase
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    // Free-running cycle / retire counters; a same-cycle CSR write wins
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mcycle   <= '0;
        minstret <= '0;
      end else begin
        mcycle   <= (csr_we && csr.csr_addr == CSR_MCYCLE)   ? wval : mcycle + XLEN'(1'b1);
        minstret <= (csr_we && csr.csr_addr == CSR_MINSTRET) ? wval : minstret + XLEN'(instr_retire);
      end
    end
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Scoreboard bench for csr_mtrap_unit (XLEN=64). A driver issues one
// stimulus per cycle and pushes the expected response computed by an
// architectural model; a monitor pops and compares on every falling edge.
module tb_csr_mtrap_unit;
  import csr_pkg::*;

  localparam logic [63:0] MTVEC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_retire, exc_valid, mret, irq_timer, irq_ext, irq_take, redirect_valid;
  logic [63:0] exc_cause, exc_pc, exc_tval, irq_pc, redirect_pc;

  csr_mtrap_unit_if #(.XLEN(64)) csr_bus ();

  csr_mtrap_unit #(.XLEN(64), .MTVEC_RST(MTVEC_RST), .HAS_COUNTERS(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr            (csr_bus),
    .instr_retire   (instr_retire),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .irq_timer      (irq_timer),
    .irq_ext        (irq_ext),
    .irq_pc         (irq_pc),
    .irq_take       (irq_take),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    bit          retire, exc, mret, it, ie;
    logic [63:0] ecause, epc, etval, ipc;
    bit          lit_rd_en, lit_rpc_en;
    logic [63:0] lit_rd, lit_rpc;
    string       tag;
  } stim_t;

  typedef struct {
    logic [63:0] rdata;
    bit          illegal, take, rv;
    logic [63:0] rpc;
    bit          lit_rd_en, lit_rpc_en;
    logic [63:0] lit_rd, lit_rpc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural model state
  bit          m_mie, m_mpie, m_mtie, m_meie, m_rv;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret, m_rpc;

  logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_rv = 0;
    m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mcycle = 0; m_minstret = 0; m_rpc = 0;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a, input bit it, input bit ie,
                                         output bit known);
    known = 1;
    case (a)
      12'h300: return 64'h1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
      12'h304: return (64'(m_mtie) << 7) | (64'(m_meie) << 11);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (64'(it) << 7) | (64'(ie) << 11);
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return 64'h0;
      default: begin known = 0; return 64'h0; end
    endcase
  endfunction

  // Advance the model across one clock edge
  function automatic void m_step(input stim_t s, input logic [63:0] old, input bit ill);
    logic [63:0] mc, mi, nv, base;
    logic [3:0]  code;
    bit          take, wr;
    wr   = (s.op == 2'b01) || (s.op != 2'b00 && s.wdata != 0);
    take = m_mie && !s.exc && ((s.ie && m_meie) || (s.it && m_mtie));
    mc   = m_mcycle + 1;
    mi   = m_minstret + 64'(s.retire);
    base = m_mtvec & ~64'h3;
    m_rv = 0;
    if (s.exc || take) begin
      if (s.exc) begin
        m_mcause = s.ecause; m_mepc = s.epc & ~64'h3; m_mtval = s.etval; m_rpc = base;
      end else begin
        code = (s.ie && m_meie) ? 4'd11 : 4'd7;
        m_mcause = {1'b1, 59'd0, code}; m_mepc = s.ipc & ~64'h3; m_mtval = 0;
        m_rpc = (m_mtvec[1:0] == 2'b01) ? base + 4 * 64'(code) : base;
      end
      m_mpie = m_mie; m_mie = 0; m_rv = 1;
    end else if (s.mret) begin
      m_mie = m_mpie; m_mpie = 1; m_rv = 1; m_rpc = m_mepc;
    end else if (s.op != 2'b00 && !ill && wr) begin
      nv = (s.op == 2'b01) ? s.wdata : (s.op == 2'b10) ? (old | s.wdata) : (old & ~s.wdata);
      case (s.addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~64'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: mc = nv;
        12'hB02: mi = nv;
        default: ;
      endcase
    end
    m_mcycle = mc; m_minstret = mi;
  endfunction

  // Drive one cycle, queue the expected response, advance the model
  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [63:0] old;
    bit          known, access, wr, ill;
    rst_n = !s.rst;
    csr_bus.csr_addr = s.addr; csr_bus.csr_op = csr_op_e'(s.op); csr_bus.csr_wdata = s.wdata;
    instr_retire = s.retire; exc_valid = s.exc; exc_cause = s.ecause; exc_pc = s.epc;
    exc_tval = s.etval; mret = s.mret; irq_timer = s.it; irq_ext = s.ie; irq_pc = s.ipc;
    if (s.rst) m_reset();
    old    = m_read(s.addr, s.it, s.ie, known);
    access = (s.op != 2'b00);
    wr     = (s.op == 2'b01) || (access && s.wdata != 0);
    ill    = access && (!known || (wr && s.addr[11:10] == 2'b11));
    e.rdata = (access && !ill) ? old : 64'h0;
    e.illegal = ill;
    e.take = m_mie && !s.exc && ((s.ie && m_meie) || (s.it && m_mtie));
    e.rv = m_rv; e.rpc = m_rpc;
    e.lit_rd_en = s.lit_rd_en; e.lit_rd = s.lit_rd;
    e.lit_rpc_en = s.lit_rpc_en; e.lit_rpc = s.lit_rpc; e.tag = s.tag;
    exp_q.push_back(e);
    if (!s.rst) m_step(s, old, ill);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle(input string tag);
    stim_t s;
    s.rst = 0; s.op = 2'b00; s.addr = 12'h000; s.wdata = 0;
    s.retire = 0; s.exc = 0; s.mret = 0; s.it = 0; s.ie = 0;
    s.ecause = 0; s.epc = 0; s.etval = 0; s.ipc = 0;
    s.lit_rd_en = 0; s.lit_rpc_en = 0; s.lit_rd = 0; s.lit_rpc = 0; s.tag = tag;
    return s;
  endfunction

  task automatic acc(input string tag, input logic [1:0] op, input logic [11:0] a,
                     input logic [63:0] w);
    stim_t s = idle(tag);
    s.op = op; s.addr = a; s.wdata = w;
    cycle(s);
  endtask

  task automatic rd_lit(input string tag, input logic [11:0] a, input logic [63:0] v);
    stim_t s = idle(tag);
    s.op = 2'b10; s.addr = a; s.lit_rd_en = 1; s.lit_rd = v;
    cycle(s);
  endtask

  // Monitor: compare DUT outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".rdata"},    csr_bus.csr_rdata,       e.rdata);
        check({e.tag, ".illegal"},  64'(csr_bus.csr_illegal), 64'(e.illegal));
        check({e.tag, ".irq_take"}, 64'(irq_take),            64'(e.take));
        check({e.tag, ".redir_v"},  64'(redirect_valid),      64'(e.rv));
        if (e.rv)         check({e.tag, ".redir_pc"},     redirect_pc,       e.rpc);
        if (e.lit_rd_en)  check({e.tag, ".rdata_lit"},    csr_bus.csr_rdata, e.lit_rd);
        if (e.lit_rpc_en) check({e.tag, ".redir_pc_lit"}, redirect_pc,       e.lit_rpc);
      end
    end
  end

  initial begin
    stim_t s;
    bit    it_l = 0, ie_l = 0;
    int    pick;

    rst_n = 0;
    csr_bus.csr_addr = 0; csr_bus.csr_op = CSR_OP_NONE; csr_bus.csr_wdata = 0;
    instr_retire = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    mret = 0; irq_timer = 0; irq_ext = 0; irq_pc = 0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset values and read-only protection
    s = idle("t1_in_reset"); s.rst = 1; s.op = 2'b10; s.addr = 12'h305;
    s.lit_rd_en = 1; s.lit_rd = MTVEC_RST; cycle(s);
    rd_lit("t1_mtvec", 12'h305, MTVEC_RST);
    rd_lit("t1_mstatus", 12'h300, 64'h1800);
    rd_lit("t1_mhartid", 12'hF14, 64'h0);
    acc("t1_wr_mhartid", 2'b01, 12'hF14, 64'h55);
    rd_lit("t1_mhartid_after", 12'hF14, 64'h0);
    acc("t1_unknown", 2'b10, 12'h7C0, 64'h0);

    // 2: RW / RS / RC on mscratch, zero-operand RS to read-only
    acc("t2_rw", 2'b01, 12'h340, 64'hA5);
    s = idle("t2_rs"); s.op = 2'b10; s.addr = 12'h340; s.wdata = 64'h0F;
    s.lit_rd_en = 1; s.lit_rd = 64'hA5; cycle(s);
    s = idle("t2_rc"); s.op = 2'b11; s.addr = 12'h340; s.wdata = 64'h05;
    s.lit_rd_en = 1; s.lit_rd = 64'hAF; cycle(s);
    rd_lit("t2_final", 12'h340, 64'hAA);
    acc("t2_rs0_mhartid", 2'b10, 12'hF14, 64'h0);

    // 3: vectored timer interrupt
    acc("t3_mtvec", 2'b01, 12'h305, 64'h8000_0001);
    acc("t3_mie", 2'b01, 12'h304, 64'h80);
    acc("t3_mstatus", 2'b01, 12'h300, 64'h8);
    s = idle("t3_irq"); s.it = 1; s.ipc = 64'h100; cycle(s);
    s = idle("t3_after"); s.op = 2'b10; s.addr = 12'h342;
    s.lit_rd_en = 1; s.lit_rd = 64'h8000_0000_0000_0007;
    s.lit_rpc_en = 1; s.lit_rpc = 64'h8000_001C; cycle(s);
    rd_lit("t3_mepc", 12'h341, 64'h100);
    rd_lit("t3_mstatus", 12'h300, 64'h1880);

    // 4: exception beats pending interrupt, then mret
    acc("t4_mie_on", 2'b10, 12'h300, 64'h8);
    s = idle("t4_exc"); s.it = 1; s.ipc = 64'h300; s.exc = 1;
    s.ecause = 64'hB; s.epc = 64'h204; s.etval = 64'h55; cycle(s);
    s = idle("t4_after"); s.op = 2'b10; s.addr = 12'h341;
    s.lit_rd_en = 1; s.lit_rd = 64'h204;
    s.lit_rpc_en = 1; s.lit_rpc = 64'h8000_0000; cycle(s);
    s = idle("t4_mret"); s.mret = 1; cycle(s);
    s = idle("t4_after_mret"); s.op = 2'b10; s.addr = 12'h300;
    s.lit_rd_en = 1; s.lit_rd = 64'h1888;
    s.lit_rpc_en = 1; s.lit_rpc = 64'h204; cycle(s);

    // 5: counter write priority and wrap
    acc("t5_clr_minstret", 2'b01, 12'hB02, 64'h0);
    s = idle("t5_wr_mcycle"); s.op = 2'b01; s.addr = 12'hB00;
    s.wdata = 64'hFFFF_FFFF_FFFF_FFFE; s.retire = 1; cycle(s);
    s = idle("t5_ret"); s.retire = 1; cycle(s); cycle(s);
    rd_lit("t5_minstret", 12'hB02, 64'h3);
    rd_lit("t5_mcycle", 12'hB00, 64'h1);
    s = idle("t5_wr_vs_ret"); s.op = 2'b01; s.addr = 12'hB02; s.wdata = 64'h10;
    s.retire = 1; cycle(s);
    rd_lit("t5_minstret2", 12'hB02, 64'h10);

    // 6: reset in the cycle after a trap drops the redirect
    s = idle("t6_exc"); s.exc = 1; s.ecause = 64'h2; s.epc = 64'h400; cycle(s);
    s = idle("t6_rst"); s.rst = 1; s.op = 2'b10; s.addr = 12'h305;
    s.lit_rd_en = 1; s.lit_rd = MTVEC_RST; cycle(s);
    s = idle("t6_rst2"); s.rst = 1; cycle(s);
    rd_lit("t6_mepc", 12'h341, 64'h0);
    rd_lit("t6_mstatus", 12'h300, 64'h1800);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle("rand");
      s.op = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 13);
      if (pick < 11)       s.addr = addrs[pick];
      else if (pick == 11) s.addr = 12'hC00;
      else                 s.addr = 12'($urandom);
      case ($urandom_range(0, 3))
        0:       s.wdata = 64'h0;
        1:       s.wdata = 64'($urandom_range(0, 4095));
        default: s.wdata = {$urandom, $urandom};
      endcase
      s.retire = 1'($urandom_range(0, 1));
      s.exc    = ($urandom_range(0, 15) == 0);
      s.ecause = 64'($urandom_range(0, 15));
      s.epc    = {$urandom, $urandom};
      s.etval  = {$urandom, $urandom};
      s.mret   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) it_l = ~it_l;
      if ($urandom_range(0, 7) == 0) ie_l = ~ie_l;
      s.it  = it_l;
      s.ie  = ie_l;
      s.ipc = {$urandom, $urandom};
      cycle(s);
    end

    s = idle("drain"); cycle(s);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
